omdisc_glue: RTL and testbench

OMDISC_GLUE -- requirements
Module: omdisc_glue

---
 rtl/omdisc_glue.sv | 208 ++++++++++++++++++++
 tb/tb_omdisc_glue.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/omdisc_glue.sv
// Oric disc controller glue: 6502 bus decode, PH2-synchronised FDC strobes,
// control register, ROM/overlay mapping, drive/motor control and FDC clock enable.
module omdisc_glue #(
    parameter logic [3:0] BASE          = 4'h1,
    parameter int         NUM_DRIVES    = 4,
    parameter int         CLK_DIV       = 6,
    parameter int         MOTOR_TIMEOUT = 48000000
) (
    input  logic                  CLK_SYS,
    input  logic                  RESET,
    input  logic [15:0]           A,
    input  logic [7:0]            DI,
    output logic [7:0]            DO,
    output logic                  DO_OE,
    input  logic                  RnW,
    input  logic                  PH2,
    input  logic                  IO,
    input  logic                  ENA,
    output logic                  nIRQ,
    output logic                  nROMDIS,
    output logic                  nMAP,
    output logic                  IOCTRL,
    output logic                  nECE,
    output logic                  nEOE,
    output logic                  fdc_ce,
    output logic                  fdc_cs,
    output logic                  fdc_rd,
    output logic                  fdc_wr,
    output logic [1:0]            fdc_addr,
    output logic [7:0]            fdc_wdata,
    input  logic [7:0]            fdc_rdata,
    input  logic                  fdc_irq,
    input  logic                  fdc_drq,
    output logic [NUM_DRIVES-1:0] drive_sel,
    output logic                  side,
    output logic                  motor_on,
    output logic                  fd_led
);

    localparam int TW = $clog2(MOTOR_TIMEOUT + 1);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic          ph2_s1_q, ph2_s2_q, ph2_s3_q;
    logic          settle_q, settle_d;
    logic          seen_low_q, seen_low_d;
    logic          armed_q, armed_d;
    logic          fdc_cs_q, fdc_cs_d;
    logic          fdc_rd_q, fdc_rd_d;
    logic          fdc_wr_q, fdc_wr_d;
    logic [1:0]    fdc_addr_q, fdc_addr_d;
    logic [7:0]    fdc_wdata_q, fdc_wdata_d;
    logic          nromen_q, nromen_d;
    logic [1:0]    dsel_q, dsel_d;
    logic          side_q, side_d;
    logic          irqen_q, irqen_d;
    logic          nromdis_q, nromdis_d;
    logic          motor_q, motor_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] ce_cnt_q, ce_cnt_d;

    logic       sel;
    logic [1:0] region;
    logic       ph2_rise, ph2_fall_raw, ph2_fall;
    logic       rd_go, wr_go, ctl_go;
    logic       u16k;
    logic       unused_bits;

    assign unused_bits = ^{A[12:8], DI[2]};

    assign region = A[3:2];
    assign sel    = (A[7:4] == BASE) & ~IO & (A[3:2] != 2'b11);

    // A rise only counts once PH2 has been seen low since reset, and a fall
    // only counts if its rise did, so a cycle cut by reset never commits.
    assign ph2_rise     = ph2_s2_q & ~ph2_s3_q & seen_low_q;
    assign ph2_fall_raw = ~ph2_s2_q & ph2_s3_q;
    assign ph2_fall     = ph2_fall_raw & armed_q;

    assign rd_go  = ph2_rise & sel & (region == 2'd0) & RnW;
    assign wr_go  = ph2_fall & sel & (region == 2'd0) & ~RnW;
    assign ctl_go = ph2_fall & sel & (region == 2'd1) & ~RnW;

    always_comb begin
        settle_d    = 1'b1;
        seen_low_d  = seen_low_q | (settle_q & ~ph2_s1_q);
        armed_d     = armed_q;
        if (ph2_rise)
            armed_d = 1'b1;
        else if (ph2_fall_raw)
            armed_d = 1'b0;

        fdc_cs_d    = rd_go | wr_go;
        fdc_rd_d    = rd_go;
        fdc_wr_d    = wr_go;
        fdc_addr_d  = (rd_go | wr_go) ? A[1:0] : fdc_addr_q;
        fdc_wdata_d = wr_go ? DI : fdc_wdata_q;

        nromen_d  = nromen_q;
        dsel_d    = dsel_q;
        side_d    = side_q;
        nromdis_d = nromdis_q;
        irqen_d   = irqen_q;
        if (ctl_go) begin
            nromen_d  = DI[7];
            dsel_d    = DI[6:5];
            side_d    = DI[4];
            nromdis_d = DI[1];
            irqen_d   = DI[0];
        end

        motor_d = motor_q;
        timer_d = timer_q;
        if (fdc_cs_q | (ctl_go & DI[3])) begin
            timer_d = TW'(MOTOR_TIMEOUT);
            motor_d = 1'b1;
        end else if (ctl_go) begin
            timer_d = '0;
            motor_d = 1'b0;
        end else if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
            if (timer_q == TW'(1))
                motor_d = 1'b0;
        end

        ce_cnt_d = (ce_cnt_q == CW'(CLK_DIV - 1)) ? '0 : ce_cnt_q + CW'(1);
    end

    always_ff @(posedge CLK_SYS) begin
        if (RESET) begin
            ph2_s1_q    <= 1'b0;
            ph2_s2_q    <= 1'b0;
            ph2_s3_q    <= 1'b0;
            settle_q    <= 1'b0;
            seen_low_q  <= 1'b0;
            armed_q     <= 1'b0;
            fdc_cs_q    <= 1'b0;
            fdc_rd_q    <= 1'b0;
            fdc_wr_q    <= 1'b0;
            fdc_addr_q  <= 2'd0;
            fdc_wdata_q <= 8'd0;
            nromen_q    <= 1'b0;
            dsel_q      <= 2'd0;
            side_q      <= 1'b0;
            irqen_q     <= 1'b0;
            nromdis_q   <= ENA;
            motor_q     <= 1'b0;
            timer_q     <= '0;
            ce_cnt_q    <= '0;
        end else begin
            ph2_s1_q    <= PH2;
            ph2_s2_q    <= ph2_s1_q;
            ph2_s3_q    <= ph2_s2_q;
            settle_q    <= settle_d;
            seen_low_q  <= seen_low_d;
            armed_q     <= armed_d;
            fdc_cs_q    <= fdc_cs_d;
            fdc_rd_q    <= fdc_rd_d;
            fdc_wr_q    <= fdc_wr_d;
            fdc_addr_q  <= fdc_addr_d;
            fdc_wdata_q <= fdc_wdata_d;
            nromen_q    <= nromen_d;
            dsel_q      <= dsel_d;
            side_q      <= side_d;
            irqen_q     <= irqen_d;
            nromdis_q   <= nromdis_d;
            motor_q     <= motor_d;
            timer_q     <= timer_d;
            ce_cnt_q    <= ce_cnt_d;
        end
    end

    always_comb begin
        DO = 8'hFF;
        if (DO_OE) begin
            case (region)
                2'd0:    DO = fdc_rdata;
                2'd1:    DO = {~fdc_irq, 7'b0};
                2'd2:    DO = {~fdc_drq, motor_q, 6'b0};
                default: DO = 8'hFF;
            endcase
        end
    end

    always_comb begin
        drive_sel = '0;
        for (int i = 0; i < NUM_DRIVES; i++)
            drive_sel[i] = (dsel_q == 2'(i));
    end

    assign DO_OE     = sel & RnW & PH2;
    assign IOCTRL    = ~sel;
    assign nIRQ      = ~(fdc_irq & irqen_q);
    assign nROMDIS   = nromdis_q;
    assign u16k      = ~nromdis_q & A[15] & A[14];
    assign nECE      = ~(A[13] & u16k & ~nromen_q);
    assign nMAP      = ~(PH2 & nECE & u16k);
    assign nEOE      = PH2 | ~RnW;
    assign fdc_ce    = (ce_cnt_q == '0);
    assign fdc_cs    = fdc_cs_q;
    assign fdc_rd    = fdc_rd_q;
    assign fdc_wr    = fdc_wr_q;
    assign fdc_addr  = fdc_addr_q;
    assign fdc_wdata = fdc_wdata_q;
    assign side      = side_q;
    assign motor_on  = motor_q;
    assign fd_led    = motor_q;

endmodule

// File: tb/tb_omdisc_glue.sv
// Bench for omdisc_glue: directed bus cycles, a latency-based reference model
// checked every cycle, and literal expectations for the headline scenarios.
module tb_omdisc_glue;

    localparam int TMO = 10;
    localparam int CD  = 6;
    localparam int LAT = 2;   // model: a PH2 edge seen at a clock acts two clocks later

    logic        CLK_SYS = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] A = 16'h0000;
    logic [7:0]  DI = 8'h00;
    logic        RnW = 1'b1;
    logic        PH2 = 1'b0;
    logic        IO = 1'b1;
    logic        ENA = 1'b1;
    logic [7:0]  fdc_rdata = 8'h00;
    logic        fdc_irq = 1'b0;
    logic        fdc_drq = 1'b0;

    logic [7:0] DO;
    logic       DO_OE, nIRQ, nROMDIS, nMAP, IOCTRL, nECE, nEOE, fdc_ce;
    logic       fdc_cs, fdc_rd, fdc_wr, side, motor_on, fd_led;
    logic [1:0] fdc_addr;
    logic [7:0] fdc_wdata;
    logic [3:0] drive_sel;

    logic [7:0] b_DO;
    logic       b_DO_OE, b_nIRQ, b_nROMDIS, b_nMAP, b_IOCTRL, b_nECE, b_nEOE, b_fdc_ce;
    logic       b_fdc_cs, b_fdc_rd, b_fdc_wr, b_side, b_motor_on, b_fd_led;
    logic [1:0] b_fdc_addr;
    logic [7:0] b_fdc_wdata;
    logic [1:0] b_drive_sel;

    omdisc_glue #(.BASE(4'h1), .NUM_DRIVES(4), .CLK_DIV(CD), .MOTOR_TIMEOUT(TMO)) dut (
        .CLK_SYS(CLK_SYS), .RESET(RESET), .A(A), .DI(DI), .DO(DO), .DO_OE(DO_OE),
        .RnW(RnW), .PH2(PH2), .IO(IO), .ENA(ENA), .nIRQ(nIRQ), .nROMDIS(nROMDIS),
        .nMAP(nMAP), .IOCTRL(IOCTRL), .nECE(nECE), .nEOE(nEOE), .fdc_ce(fdc_ce),
        .fdc_cs(fdc_cs), .fdc_rd(fdc_rd), .fdc_wr(fdc_wr), .fdc_addr(fdc_addr),
        .fdc_wdata(fdc_wdata), .fdc_rdata(fdc_rdata), .fdc_irq(fdc_irq), .fdc_drq(fdc_drq),
        .drive_sel(drive_sel), .side(side), .motor_on(motor_on), .fd_led(fd_led));

    omdisc_glue #(.BASE(4'h1), .NUM_DRIVES(2), .CLK_DIV(CD), .MOTOR_TIMEOUT(TMO)) dut2 (
        .CLK_SYS(CLK_SYS), .RESET(RESET), .A(A), .DI(DI), .DO(b_DO), .DO_OE(b_DO_OE),
        .RnW(RnW), .PH2(PH2), .IO(IO), .ENA(ENA), .nIRQ(b_nIRQ), .nROMDIS(b_nROMDIS),
        .nMAP(b_nMAP), .IOCTRL(b_IOCTRL), .nECE(b_nECE), .nEOE(b_nEOE), .fdc_ce(b_fdc_ce),
        .fdc_cs(b_fdc_cs), .fdc_rd(b_fdc_rd), .fdc_wr(b_fdc_wr), .fdc_addr(b_fdc_addr),
        .fdc_wdata(b_fdc_wdata), .fdc_rdata(fdc_rdata), .fdc_irq(fdc_irq), .fdc_drq(fdc_drq),
        .drive_sel(b_drive_sel), .side(b_side), .motor_on(b_motor_on), .fd_led(b_fd_led));

    always #5 CLK_SYS = ~CLK_SYS;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        bit         rise;
        bit         sel;
        logic [1:0] rgn;
        bit         rnw;
        logic [1:0] a10;
        logic [7:0] di;
    } ev_t;

    ev_t        evq[$];
    bit         mvalid = 0;
    bit         prev_ph2 = 1;
    bit         m_armed = 0;
    bit         m_cs = 0, m_rd = 0, m_wr = 0;
    logic [1:0] m_addr = 0;
    logic [7:0] m_wdata = 0;
    bit         m_nromen = 0, m_side = 0, m_irqen = 0, m_nromdis = 1;
    logic [1:0] m_dsel = 0;
    int         mot_from = 0, mot_until = 0, ce_base = 0;

    function automatic bit bus_sel();
        return (A[7:4] == 4'h1) && !IO && (A[3:2] != 2'b11);
    endfunction

    function automatic bit mot_at(input int c);
        return (c >= mot_from) && (c < mot_until);
    endfunction

    always @(posedge CLK_SYS) begin
        ev_t e;
        cyc++;
        if (RESET) begin
            mvalid = 1; evq.delete(); prev_ph2 = 1; m_armed = 0;
            m_cs = 0; m_rd = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
            m_nromen = 0; m_dsel = 0; m_side = 0; m_irqen = 0; m_nromdis = ENA;
            mot_from = 0; mot_until = 0; ce_base = cyc;
        end else begin
            m_cs = 0; m_rd = 0; m_wr = 0;
            while (evq.size() > 0 && evq[0].due == cyc) begin
                e = evq.pop_front();
                if (e.rise) begin
                    m_armed = 1;
                    if (e.sel && e.rgn == 0 && e.rnw) begin
                        m_cs = 1; m_rd = 1; m_addr = e.a10;
                        if (!mot_at(cyc)) mot_from = cyc + 1;
                        mot_until = cyc + 1 + TMO;
                    end
                end else if (m_armed) begin
                    m_armed = 0;
                    if (e.sel && !e.rnw && e.rgn == 0) begin
                        m_cs = 1; m_wr = 1; m_addr = e.a10; m_wdata = e.di;
                        if (!mot_at(cyc)) mot_from = cyc + 1;
                        mot_until = cyc + 1 + TMO;
                    end else if (e.sel && !e.rnw && e.rgn == 1) begin
                        m_nromen = e.di[7]; m_dsel = e.di[6:5]; m_side = e.di[4];
                        m_nromdis = e.di[1]; m_irqen = e.di[0];
                        if (e.di[3]) begin
                            if (!mot_at(cyc)) mot_from = cyc;
                            mot_until = cyc + TMO;
                        end else mot_until = cyc;
                    end
                end
            end
            if (PH2 != prev_ph2) begin
                e.due = cyc + LAT; e.rise = PH2; e.sel = bus_sel(); e.rgn = A[3:2];
                e.rnw = RnW; e.a10 = A[1:0]; e.di = DI;
                evq.push_back(e);
                prev_ph2 = PH2;
            end
        end
    end

    always @(negedge CLK_SYS) begin
        bit         mot, u16k, ece, oe;
        logic [7:0] dexp;
        if (mvalid) begin
            mot  = mot_at(cyc);
            u16k = !m_nromdis && A[15] && A[14];
            ece  = !(A[13] && u16k && !m_nromen);
            oe   = bus_sel() && RnW && PH2;
            dexp = 8'hFF;
            if (oe) begin
                if (A[3:2] == 0) dexp = fdc_rdata;
                else if (A[3:2] == 1) dexp = fdc_irq ? 8'h00 : 8'h80;
                else dexp = {!fdc_drq, mot, 6'b0};
            end
            chk("motor_on", motor_on, mot);
            chk("fd_led", fd_led, mot);
            chk("fdc_ce", fdc_ce, ((cyc - ce_base) % CD) == 0);
            chk("fdc_cs", fdc_cs, m_cs);
            chk("fdc_rd", fdc_rd, m_rd);
            chk("fdc_wr", fdc_wr, m_wr);
            if (m_cs) chk("fdc_addr", fdc_addr, m_addr);
            if (m_wr) chk("fdc_wdata", fdc_wdata, m_wdata);
            chk("DO_OE", DO_OE, oe);
            chk("DO", DO, dexp);
            chk("IOCTRL", IOCTRL, !bus_sel());
            chk("nIRQ", nIRQ, !(fdc_irq && m_irqen));
            chk("nROMDIS", nROMDIS, m_nromdis);
            chk("side", side, m_side);
            chk("drive_sel", drive_sel, 4'b0001 << m_dsel);
            chk("drive_sel2", b_drive_sel, (m_dsel < 2) ? (2'b01 << m_dsel) : 2'b00);
            chk("nECE", nECE, ece);
            chk("nMAP", nMAP, !(PH2 && ece && u16k));
            chk("nEOE", nEOE, PH2 || !RnW);
        end
    end

    // ---------------- activity monitors ----------------
    int rd_cnt = 0, wr_cnt = 0, cs_cnt = 0, mot_cnt = 0;
    always @(negedge CLK_SYS) begin
        if (fdc_rd) rd_cnt++;
        if (fdc_wr) wr_cnt++;
        if (fdc_cs) cs_cnt++;
        if (motor_on) mot_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge CLK_SYS);
        #1;
    endtask

    task automatic bus_setup(input logic [15:0] a, input logic rnw, input logic [7:0] d);
        tick(1);
        A = a; IO = (a[15:8] != 8'h03); RnW = rnw; DI = d;
    endtask

    task automatic bus_idle();
        A = 16'h0000; IO = 1'b1; RnW = 1'b1; DI = 8'h00;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus_setup(a, 1'b0, d);
        tick(2); PH2 = 1'b1;
        tick(6); PH2 = 1'b0;
        tick(5); bus_idle();
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic oe,
                            output logic ioc);
        bus_setup(a, 1'b1, 8'h00);
        tick(2); PH2 = 1'b1;
        tick(4); d = DO; oe = DO_OE; ioc = IOCTRL;
        tick(2); PH2 = 1'b0;
        tick(5); bus_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic       oe, ioc;
        int         k;
        bit         got;

        RESET = 1'b1; ENA = 1'b1;
        tick(3); RESET = 1'b0;
        tick(2);
        chk("rst_nROMDIS", nROMDIS, 1'b1);
        chk("rst_drive_sel", drive_sel, 4'b0001);
        chk("rst_motor_on", motor_on, 1'b0);
        chk("rst_nIRQ", nIRQ, 1'b1);

        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (fdc_ce) got = 1; else tick(1);
        end
        k = 0;
        if (got) begin
            for (int i = 1; i <= 20 && k == 0; i++) begin
                tick(1);
                if (fdc_ce) k = i;
            end
        end
        chk("ce_period", k, CD);

        // control write 0xDB
        bus_write(16'h0314, 8'hDB);
        chk("ctl_drive_sel", drive_sel, 4'b0100);
        chk("ctl_side", side, 1'b1);
        chk("ctl_motor", motor_on, 1'b1);
        chk("ctl_nROMDIS", nROMDIS, 1'b1);
        chk("ctl_no_fdc", cs_cnt, 0);

        // interrupt path
        fdc_irq = 1'b1; tick(1);
        chk("irq_nIRQ_on", nIRQ, 1'b0);
        bus_read(16'h0314, d, oe, ioc);
        chk("irq_status_DO", d, 8'h00);
        chk("irq_status_OE", oe, 1'b1);
        bus_write(16'h0314, 8'hDA);
        chk("irq_nIRQ_off", nIRQ, 1'b1);
        fdc_irq = 1'b0;

        // FDC register read and write
        fdc_rdata = 8'h5A; rd_cnt = 0;
        bus_read(16'h0311, d, oe, ioc);
        chk("fdc_read_DO", d, 8'h5A);
        chk("fdc_read_OE", oe, 1'b1);
        chk("fdc_read_pulses", rd_cnt, 1);
        chk("fdc_read_addr", fdc_addr, 2'd1);
        wr_cnt = 0;
        bus_write(16'h0312, 8'h3C);
        chk("fdc_write_pulses", wr_cnt, 1);
        chk("fdc_write_data", fdc_wdata, 8'h3C);
        chk("fdc_write_addr", fdc_addr, 2'd2);

        // ROM/overlay mapping, ROM disabled, overlay enabled
        bus_write(16'h0314, 8'h00);
        tick(1); A = 16'hE000; RnW = 1'b1; PH2 = 1'b1;
        tick(1);
        chk("map_nECE_E000", nECE, 1'b0);
        chk("map_nMAP_E000", nMAP, 1'b1);
        chk("map_nEOE_rd_ph2", nEOE, 1'b1);
        A = 16'hC000; tick(1);
        chk("map_nMAP_C000", nMAP, 1'b0);
        PH2 = 1'b0; tick(1);
        chk("map_nEOE_rd_ph1", nEOE, 1'b0);
        for (int i = 0; i < 8; i++) begin
            A = (i[0]) ? 16'hF123 : 16'h8A00; RnW = i[1]; PH2 = i[2];
            tick(3);
        end
        PH2 = 1'b0; bus_idle(); tick(4);
        bus_write(16'h0314, 8'h80);
        tick(1); A = 16'hE000; PH2 = 1'b1;
        tick(1);
        chk("map_nECE_romen_off", nECE, 1'b1);
        chk("map_nMAP_romen_off", nMAP, 1'b0);
        PH2 = 1'b0; bus_idle(); tick(4);

        // motor timeout and extension at count 1
        bus_write(16'h0314, 8'h00);
        tick(2); mot_cnt = 0;
        bus_write(16'h0310, 8'h11);
        tick(20);
        chk("motor_single", mot_cnt, TMO);
        mot_cnt = 0;
        bus_setup(16'h0310, 1'b0, 8'h22);
        tick(2); PH2 = 1'b1;
        tick(6); PH2 = 1'b0;
        tick(6); A = 16'h0311; RnW = 1'b1;
        tick(4); PH2 = 1'b1;
        tick(6); PH2 = 1'b0;
        tick(5); bus_idle();
        tick(20);
        chk("motor_extended", mot_cnt, 2 * TMO);

        // out-of-range drive select, status region 2, unselected slot 3
        bus_write(16'h0314, 8'h60);
        chk("dsel3_nd2", b_drive_sel, 2'b00);
        chk("dsel3_nd4", drive_sel, 4'b1000);
        fdc_drq = 1'b1;
        bus_read(16'h0318, d, oe, ioc);
        chk("drq_status_on", d, 8'h00);
        fdc_drq = 1'b0;
        bus_read(16'h0318, d, oe, ioc);
        chk("drq_status_off", d, 8'h80);
        cs_cnt = 0;
        bus_read(16'h031C, d, oe, ioc);
        chk("slot3_IOCTRL", ioc, 1'b1);
        chk("slot3_DO_OE", oe, 1'b0);
        chk("slot3_DO", d, 8'hFF);
        bus_write(16'h031C, 8'h00);
        chk("slot3_no_strobe", cs_cnt, 0);
        chk("slot3_no_commit", drive_sel, 4'b1000);
        tick(1); A = 16'h0311; IO = 1'b1; tick(1);
        chk("io_high_IOCTRL", IOCTRL, 1'b1);
        bus_idle();

        // reset in the middle of a control write, booting with ENA=0
        rd_cnt = 0; wr_cnt = 0; cs_cnt = 0;
        bus_setup(16'h0314, 1'b0, 8'hA9);
        tick(2); PH2 = 1'b1;
        tick(5); RESET = 1'b1; ENA = 1'b0;
        tick(3); RESET = 1'b0;
        tick(3); PH2 = 1'b0;
        tick(6); bus_idle();
        chk("rstmid_drive_sel", drive_sel, 4'b0001);
        chk("rstmid_motor", motor_on, 1'b0);
        chk("rstmid_nROMDIS", nROMDIS, 1'b0);
        chk("rstmid_strobes", cs_cnt, 0);
        bus_write(16'h0314, 8'h2B);
        chk("post_rst_drive_sel", drive_sel, 4'b0010);
        tick(12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
